// File: rtl/wb_arb_pkg.sv
// Shared codes for the writeback arbiter: mux selects, issue kinds, slot states.
// Latency: n/a (types and constants only). Backpressure: n/a.
package wb_arb_pkg;

    localparam logic [2:0] SEL_ALU   = 3'b000;
    localparam logic [2:0] SEL_LB    = 3'b001;
    localparam logic [2:0] SEL_LW    = 3'b010;
    localparam logic [2:0] SEL_PC    = 3'b011;
    localparam logic [2:0] SEL_MUL   = 3'b100;
    localparam logic [2:0] SEL_PC4   = 3'b101;
    localparam logic [2:0] SEL_LUI   = 3'b110;
    localparam logic [2:0] SEL_AUIPC = 3'b111;

    typedef enum logic [1:0] {
        KIND_SIMPLE = 2'b00,
        KIND_LOAD   = 2'b01,
        KIND_MUL    = 2'b10,
        KIND_ILL    = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'b00,
        SLOT_WAIT = 2'b01,
        SLOT_DONE = 2'b10
    } slot_state_e;

    // Mul ignores sel, so any value is legal for it.
    function automatic logic sel_legal(input logic [1:0] kind, input logic [2:0] sel);
        case (kind)
            KIND_SIMPLE: sel_legal = (sel == SEL_ALU) || (sel == SEL_PC) || (sel == SEL_PC4) ||
                                     (sel == SEL_LUI) || (sel == SEL_AUIPC);
            KIND_LOAD:   sel_legal = (sel == SEL_LB) || (sel == SEL_LW);
            KIND_MUL:    sel_legal = 1'b1;
            default:     sel_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One scoreboard slot (IDLE/WAIT/DONE) holding a pending rd/sel plus its hazard compare.
// Latency: state updates on the next edge; req/hazard are combinational.
// Backpressure: a slot whose write loses arbitration parks in DONE until granted.
module wb_slot
    import wb_arb_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [RD_W-1:0]  issue_rd,
    input  logic [SEL_W-1:0] issue_sel,
    input  logic             done,
    input  logic             grant,
    input  logic [RD_W-1:0]  chk_rs1,
    input  logic [RD_W-1:0]  chk_rs2,
    input  logic [RD_W-1:0]  chk_rd,
    output logic             active,
    output logic             in_done,
    output logic             req,
    output logic             hazard,
    output logic [RD_W-1:0]  slot_rd,
    output logic [SEL_W-1:0] slot_sel
);

    slot_state_e state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SLOT_IDLE;
            slot_rd  <= '0;
            slot_sel <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                slot_rd  <= issue_rd;
                slot_sel <= issue_sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_IDLE: if (issue) state_nxt = SLOT_WAIT;
            SLOT_WAIT: if (done)  state_nxt = grant ? SLOT_IDLE : SLOT_DONE;
            SLOT_DONE: if (grant) state_nxt = SLOT_IDLE;
            default:              state_nxt = SLOT_IDLE;
        endcase
    end

    assign active  = (state != SLOT_IDLE);
    assign in_done = (state == SLOT_DONE);
    // Done pulses outside WAIT never raise a request.
    assign req     = in_done || (done && (state == SLOT_WAIT));

    assign hazard = active && (((chk_rs1 != '0) && (chk_rs1 == slot_rd)) ||
                               ((chk_rs2 != '0) && (chk_rs2 == slot_rd)) ||
                               ((chk_rd  != '0) && (chk_rd  == slot_rd)));

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port arbiter with LD/MUL scoreboard; optional err via WB_ARB_ERR_EN.
// Latency: write registered one cycle after the winning request or accepted simple issue.
// Backpressure: iss_ready drops on pending done traffic, hazards, or busy target unit.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic [1:0]       iss_kind,
    input  logic [SEL_W-1:0] iss_sel,
    input  logic [RD_W-1:0]  iss_rd,
    input  logic [RD_W-1:0]  iss_rs1,
    input  logic [RD_W-1:0]  iss_rs2,
    output logic             iss_ready,
    input  logic             ld_done,
    input  logic             mul_done,
    output logic             wb_we,
    output logic [SEL_W-1:0] wb_sel,
    output logic [RD_W-1:0]  wb_rd,
    output logic             busy
`ifdef WB_ARB_ERR_EN
    ,
    output logic             err
`endif
);

    logic             ld_active, ld_in_done, ld_req, ld_hz, ld_grant, ld_issue;
    logic             mul_active, mul_in_done, mul_req, mul_hz, mul_grant, mul_issue;
    logic [RD_W-1:0]  ld_rd, mul_rd;
    logic [SEL_W-1:0] ld_sel, mul_sel;
    logic             kind_ld, kind_mul, kind_simple, accept, unit_blk;

    assign kind_ld     = (iss_kind == KIND_LOAD);
    assign kind_mul    = (iss_kind == KIND_MUL);
    // Illegal kind falls through as a simple write with the given sel.
    assign kind_simple = !kind_ld && !kind_mul;

    assign unit_blk  = (kind_ld && ld_active) || (kind_mul && mul_active);
    assign iss_ready = !(ld_in_done || mul_in_done || ld_done || mul_done ||
                         ld_hz || mul_hz || unit_blk);
    assign accept    = iss_valid && iss_ready;

    assign ld_issue  = accept && kind_ld  && (iss_rd != '0);
    assign mul_issue = accept && kind_mul && (iss_rd != '0);

    assign ld_grant  = ld_req;
    assign mul_grant = mul_req && !ld_req;

    assign busy = ld_active || mul_active;

    wb_slot #(.SEL_W(SEL_W), .RD_W(RD_W)) u_ld_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (ld_issue),
        .issue_rd (iss_rd),
        .issue_sel(iss_sel),
        .done     (ld_done),
        .grant    (ld_grant),
        .chk_rs1  (iss_rs1),
        .chk_rs2  (iss_rs2),
        .chk_rd   (iss_rd),
        .active   (ld_active),
        .in_done  (ld_in_done),
        .req      (ld_req),
        .hazard   (ld_hz),
        .slot_rd  (ld_rd),
        .slot_sel (ld_sel)
    );

    wb_slot #(.SEL_W(SEL_W), .RD_W(RD_W)) u_mul_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (mul_issue),
        .issue_rd (iss_rd),
        .issue_sel(SEL_W'(SEL_MUL)),
        .done     (mul_done),
        .grant    (mul_grant),
        .chk_rs1  (iss_rs1),
        .chk_rs2  (iss_rs2),
        .chk_rd   (iss_rd),
        .active   (mul_active),
        .in_done  (mul_in_done),
        .req      (mul_req),
        .hazard   (mul_hz),
        .slot_rd  (mul_rd),
        .slot_sel (mul_sel)
    );

    // Accepted simple issues only happen with no done traffic, so they never lose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we  <= 1'b0;
            wb_sel <= '0;
            wb_rd  <= '0;
        end else if (ld_grant) begin
            wb_we  <= 1'b1;
            wb_sel <= ld_sel;
            wb_rd  <= ld_rd;
        end else if (mul_grant) begin
            wb_we  <= 1'b1;
            wb_sel <= mul_sel;
            wb_rd  <= mul_rd;
        end else if (accept && kind_simple && (iss_rd != '0)) begin
            wb_we  <= 1'b1;
            wb_sel <= iss_sel;
            wb_rd  <= iss_rd;
        end else begin
            wb_we  <= 1'b0;
        end
    end

`ifdef WB_ARB_ERR_EN
    logic err_set;

    assign err_set = (iss_valid && (iss_kind == KIND_ILL)) ||
                     (iss_valid && !sel_legal(iss_kind, 3'(iss_sel))) ||
                     (ld_done  && !(ld_active  && !ld_in_done)) ||
                     (mul_done && !(mul_active && !mul_in_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end
`endif

endmodule
